// File: rtl/vlc_tree_decoder.sv
`default_nettype none
// ============================================================================
// Module   : vlc_tree_decoder
// Brief    : Bit-serial binary code-tree walker over a synchronous table ROM.
// Revision : 1.0 - initial release
// ============================================================================
module vlc_tree_decoder #(
  parameter int SYMBOL_W   = 5,
  parameter int PTR_W      = 8,
  parameter int ROM_ADDR_W = 10,
  parameter int NUM_TABLES = 4,
  parameter int SEL_W      = 2,
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter logic [NUM_TABLES*ROM_ADDR_W-1:0] TABLE_BASE =
    {10'd192, 10'd128, 10'd64, 10'd0}
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic                      start_i,
  input  logic [SEL_W-1:0]          table_sel_i,
  input  logic                      bit_i,
  input  logic                      bit_valid_i,
  output logic                      bit_ready_o,
  output logic                      rom_en_o,
  output logic [ROM_ADDR_W-1:0]     rom_addr_o,
  input  logic [2*(PTR_W+1)-1:0]    rom_data_i,
  output logic                      sym_valid_o,
  input  logic                      sym_ready_i,
  output logic [SYMBOL_W-1:0]       sym_o,
  output logic [LEN_W-1:0]          sym_len_o,
  output logic                      err_o
);

  localparam int c_NODE_W = PTR_W + 1;
  localparam int c_SUM_W  = (PTR_W > ROM_ADDR_W) ? PTR_W : ROM_ADDR_W;
  localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
  localparam logic [PTR_W-1:0] c_INVALID = '1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WALK = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [ROM_ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]      r_len;
  logic [SYMBOL_W-1:0]   r_sym;
  logic [LEN_W-1:0]      r_sym_len;
  logic                  r_err;

  logic [ROM_ADDR_W-1:0] w_sel_base;
  logic [ROM_ADDR_W-1:0] w_node_addr;
  logic [c_SUM_W-1:0]    w_sum;
  logic [c_NODE_W-1:0]   w_node;
  logic                  w_leaf;
  logic [PTR_W-1:0]      w_payload;
  logic [LEN_W-1:0]      w_len_inc;
  logic                  w_consume;
  logic                  w_leaf_hit;
  logic                  w_err_hit;
  logic                  w_advance;
  logic                  w_holding;
  logic                  w_accept;

  // Unselected or out-of-range table indices fall back to address 0.
  always_comb begin
    w_sel_base = '0;
    for (int k = 0; k < NUM_TABLES; k++) begin
      if (table_sel_i == SEL_W'(k)) begin
        w_sel_base = TABLE_BASE[k*ROM_ADDR_W +: ROM_ADDR_W];
      end
    end
  end

  assign w_node    = bit_i ? rom_data_i[2*c_NODE_W-1:c_NODE_W]
                           : rom_data_i[c_NODE_W-1:0];
  assign w_leaf    = w_node[PTR_W];
  assign w_payload = w_node[PTR_W-1:0];
  assign w_len_inc = r_len + LEN_W'(1);

  // Child pointers are table-relative; the sum wraps silently in ROM space.
  assign w_sum       = c_SUM_W'(r_base) + c_SUM_W'(w_payload);
  assign w_node_addr = w_sum[ROM_ADDR_W-1:0];

  assign w_holding = (r_state == S_DONE) || (r_state == S_ERR);
  assign w_accept  = w_holding && sym_ready_i;

  always_comb begin
    w_state_next = r_state;
    w_consume    = 1'b0;
    w_leaf_hit   = 1'b0;
    w_err_hit    = 1'b0;
    w_advance    = 1'b0;
    if (start_i) begin
      w_state_next = S_WALK;
    end else begin
      case (r_state)
        S_IDLE: w_state_next = S_IDLE;
        S_WALK: begin
          if (bit_valid_i) begin
            w_consume = 1'b1;
            if (w_leaf) begin
              w_leaf_hit   = 1'b1;
              w_state_next = S_DONE;
            end else if ((w_payload == c_INVALID) || (w_len_inc == c_MAX_LEN)) begin
              w_err_hit    = 1'b1;
              w_state_next = S_ERR;
            end else begin
              w_advance    = 1'b1;
            end
          end
        end
        S_DONE, S_ERR: begin
          if (sym_ready_i) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // A start cycle never shifts a bit: the walk it replaces is abandoned.
  assign bit_ready_o = resetn && (r_state == S_WALK) && !start_i;
  assign rom_en_o    = resetn && (start_i || w_advance);
  assign rom_addr_o  = start_i ? w_sel_base : w_node_addr;
  assign sym_valid_o = w_holding;
  assign sym_o       = r_sym;
  assign sym_len_o   = r_sym_len;
  assign err_o       = r_err;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_state   <= S_IDLE;
      r_base    <= '0;
      r_len     <= '0;
      r_sym     <= '0;
      r_sym_len <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (start_i) begin
        r_base <= w_sel_base;
        r_len  <= '0;
        r_err  <= 1'b0;
      end else begin
        if (w_consume) begin
          r_len <= w_len_inc;
        end
        if (w_leaf_hit) begin
          r_sym     <= w_payload[SYMBOL_W-1:0];
          r_sym_len <= w_len_inc;
          r_err     <= 1'b0;
        end else if (w_err_hit) begin
          r_sym     <= '0;
          r_sym_len <= w_len_inc;
          r_err     <= 1'b1;
        end else if (w_accept) begin
          r_err     <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vlc_tree_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_vlc_tree_decoder
// Brief    : Randomised bench for vlc_tree_decoder against a tree-walk model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vlc_tree_decoder;

  localparam int SYMBOL_W   = 5;
  localparam int PTR_W      = 8;
  localparam int ROM_ADDR_W = 10;
  localparam int NUM_TABLES = 4;
  localparam int SEL_W      = 2;
  localparam int MAX_LEN    = 16;
  localparam int LEN_W      = 5;
  localparam int NODE_W     = PTR_W + 1;
  localparam logic [NUM_TABLES*ROM_ADDR_W-1:0] TABLE_BASE =
    {10'd192, 10'd128, 10'd64, 10'd0};

  int base_of [NUM_TABLES] = '{0, 64, 128, 192};

  logic                   clock = 1'b0;
  logic                   resetn;
  logic                   start_i;
  logic [SEL_W-1:0]       table_sel_i;
  logic                   bit_i;
  logic                   bit_valid_i;
  logic                   bit_ready_o;
  logic                   rom_en_o;
  logic [ROM_ADDR_W-1:0]  rom_addr_o;
  logic [2*NODE_W-1:0]    rom_data_i;
  logic                   sym_valid_o;
  logic                   sym_ready_i;
  logic [SYMBOL_W-1:0]    sym_o;
  logic [LEN_W-1:0]       sym_len_o;
  logic                   err_o;

  int n_cmp  = 0;
  int n_fail = 0;
  int last_cyc;
  int last_start_addr;

  logic [2*NODE_W-1:0] mem [0:(1<<ROM_ADDR_W)-1];

  vlc_tree_decoder #(
    .SYMBOL_W(SYMBOL_W), .PTR_W(PTR_W), .ROM_ADDR_W(ROM_ADDR_W),
    .NUM_TABLES(NUM_TABLES), .SEL_W(SEL_W), .MAX_LEN(MAX_LEN),
    .LEN_W(LEN_W), .TABLE_BASE(TABLE_BASE)
  ) dut (
    .clock(clock), .resetn(resetn), .start_i(start_i),
    .table_sel_i(table_sel_i), .bit_i(bit_i), .bit_valid_i(bit_valid_i),
    .bit_ready_o(bit_ready_o), .rom_en_o(rom_en_o), .rom_addr_o(rom_addr_o),
    .rom_data_i(rom_data_i), .sym_valid_o(sym_valid_o),
    .sym_ready_i(sym_ready_i), .sym_o(sym_o), .sym_len_o(sym_len_o),
    .err_o(err_o)
  );

  always #5 clock = ~clock;

  // Table ROM: one cycle of latency, output held while disabled.
  always @(posedge clock) begin
    if (rom_en_o) rom_data_i <= mem[rom_addr_o];
  end

  function automatic logic [NODE_W-1:0] mk(input bit leaf, input int payload);
    return {leaf, PTR_W'(payload)};
  endfunction

  // Walk the tree straight from the table contents, bit by bit.
  function automatic void model(input int sel, input logic [31:0] bits,
                                output int sym, output int len, output bit err);
    int addr;
    logic [2*NODE_W-1:0] word;
    logic [NODE_W-1:0] node;
    addr = base_of[sel];
    sym  = 0;
    len  = MAX_LEN;
    err  = 1'b1;
    for (int i = 0; i < MAX_LEN; i++) begin
      word = mem[addr];
      node = bits[i] ? word[2*NODE_W-1:NODE_W] : word[NODE_W-1:0];
      if (node[PTR_W]) begin
        sym = int'(node[SYMBOL_W-1:0]);
        len = i + 1;
        err = 1'b0;
        return;
      end
      if (node[PTR_W-1:0] == {PTR_W{1'b1}}) begin
        len = i + 1;
        return;
      end
      addr = (base_of[sel] + int'(node[PTR_W-1:0])) % (1 << ROM_ADDR_W);
    end
  endfunction

  // stall_mode: 0 none, 1 random, 2 three idle cycles after the first bit.
  task automatic run_decode(input int sel, input logic [31:0] bits,
                            input int stall_mode, input bit ack_prev,
                            input string tag);
    int  exp_sym, exp_len, cyc, idx, stalls;
    bit  exp_err, seen, v;
    model(sel, bits, exp_sym, exp_len, exp_err);
    @(negedge clock);
    start_i     = 1'b1;
    table_sel_i = SEL_W'(sel);
    sym_ready_i = ack_prev;
    bit_valid_i = 1'($urandom_range(0, 1));
    bit_i       = 1'($urandom_range(0, 1));
    #1;
    last_start_addr = int'(rom_addr_o);
    n_cmp++;
    if (rom_addr_o !== ROM_ADDR_W'(base_of[sel]) || rom_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s start_fetch: addr=%0d en=%b, expected addr=%0d en=1",
               tag, rom_addr_o, rom_en_o, base_of[sel]);
    end
    idx = 0; stalls = 0; cyc = 0; seen = 1'b0;
    for (int k = 0; k < 4*MAX_LEN + 40 && !seen; k++) begin
      @(negedge clock);
      start_i     = 1'b0;
      sym_ready_i = 1'b0;
      cyc++;
      case (stall_mode)
        1:       v = ($urandom_range(0, 99) >= 30);
        2:       v = !(idx == 1 && stalls < 3);
        default: v = 1'b1;
      endcase
      bit_valid_i = v;
      bit_i       = bits[idx];
      #1;
      if (sym_valid_o) begin
        seen = 1'b1;
      end else if (bit_ready_o !== 1'b1) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s bit_ready_walk: got %b, expected 1 at cycle %0d", tag, bit_ready_o, cyc);
      end else if (bit_valid_i) begin
        idx++;
      end else begin
        stalls++;
        n_cmp++;
        if (rom_en_o !== 1'b0) begin
          n_fail++;
          $display("FAIL %s rom_en_stall: got %b, expected 0", tag, rom_en_o);
        end
      end
    end
    last_cyc = cyc;
    n_cmp++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no sym_valid after %0d cycles, expected one", tag, cyc);
      return;
    end
    if (cyc != exp_len + stalls + 1 || idx != exp_len) begin
      n_fail++;
      $display("FAIL %s latency: valid at cycle %0d after %0d bits, expected cycle %0d after %0d bits",
               tag, cyc, idx, exp_len + stalls + 1, exp_len);
    end
    n_cmp++;
    if (err_o !== exp_err || sym_o !== SYMBOL_W'(exp_sym)) begin
      n_fail++;
      $display("FAIL %s result: err=%b sym=%0d, expected err=%b sym=%0d",
               tag, err_o, sym_o, exp_err, exp_sym);
    end
    if (!exp_err) begin
      n_cmp++;
      if (sym_len_o !== LEN_W'(exp_len)) begin
        n_fail++;
        $display("FAIL %s length: got %0d, expected %0d", tag, sym_len_o, exp_len);
      end
    end
  endtask

  task automatic accept_result(input string tag);
    @(negedge clock);
    start_i     = 1'b0;
    sym_ready_i = 1'b1;
    bit_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (sym_valid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL %s held_before_accept: sym_valid=%b, expected 1", tag, sym_valid_o);
    end
    @(negedge clock);
    sym_ready_i = 1'b0;
    #1;
    n_cmp++;
    if (sym_valid_o !== 1'b0 || bit_ready_o !== 1'b0 || rom_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after_accept: valid=%b ready=%b en=%b, expected 0 0 0",
               tag, sym_valid_o, bit_ready_o, rom_en_o);
    end
  endtask

  task automatic test_reset();
    resetn      = 1'b0;
    start_i     = 1'b1;
    table_sel_i = 2'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      n_cmp++;
      if (rom_en_o !== 1'b0 || sym_valid_o !== 1'b0 || err_o !== 1'b0 ||
          sym_o !== '0 || sym_len_o !== '0 || bit_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: en=%b valid=%b err=%b sym=%0d len=%0d ready=%b, expected all 0",
                 rom_en_o, sym_valid_o, err_o, sym_o, sym_len_o, bit_ready_o);
      end
    end
    @(negedge clock);
    resetn  = 1'b1;
    start_i = 1'b0;
    @(negedge clock);
    #1;
    n_cmp++;
    if (sym_valid_o !== 1'b0 || bit_ready_o !== 1'b0 || rom_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: valid=%b ready=%b en=%b, expected 0 0 0",
               sym_valid_o, bit_ready_o, rom_en_o);
    end
  endtask

  task automatic test_short_code();
    run_decode(0, 32'b1, 0, 1'b0, "short");
    n_cmp++;
    if (sym_o !== 5'd5 || sym_len_o !== 5'd1 || err_o !== 1'b0 || last_cyc != 2) begin
      n_fail++;
      $display("FAIL short_plan: sym=%0d len=%0d err=%b cycle=%0d, expected 5 1 0 2",
               sym_o, sym_len_o, err_o, last_cyc);
    end
    accept_result("short");
  endtask

  task automatic test_stall();
    run_decode(0, 32'b00, 2, 1'b0, "stall");
    n_cmp++;
    if (sym_o !== 5'd3 || sym_len_o !== 5'd2 || err_o !== 1'b0 || last_cyc != 6) begin
      n_fail++;
      $display("FAIL stall_plan: sym=%0d len=%0d err=%b cycle=%0d, expected 3 2 0 6",
               sym_o, sym_len_o, err_o, last_cyc);
    end
    accept_result("stall");
  endtask

  task automatic test_invalid();
    run_decode(0, 32'b10, 0, 1'b0, "invalid");
    n_cmp++;
    if (err_o !== 1'b1 || sym_o !== 5'd0 || last_cyc != 3) begin
      n_fail++;
      $display("FAIL invalid_plan: err=%b sym=%0d cycle=%0d, expected 1 0 3", err_o, sym_o, last_cyc);
    end
    accept_result("invalid");
  endtask

  task automatic test_overlength();
    run_decode(3, $urandom, 1, 1'b0, "overlen");
    n_cmp++;
    if (err_o !== 1'b1) begin
      n_fail++;
      $display("FAIL overlen_plan: err=%b, expected 1", err_o);
    end
    accept_result("overlen");
  endtask

  task automatic test_backpressure();
    run_decode(0, 32'b1, 0, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      sym_ready_i = 1'b0;
      bit_valid_i = 1'b1;
      bit_i       = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (sym_valid_o !== 1'b1 || sym_o !== 5'd5 || sym_len_o !== 5'd1 ||
          err_o !== 1'b0 || bit_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold: valid=%b sym=%0d len=%0d err=%b ready=%b, expected 1 5 1 0 0",
                 sym_valid_o, sym_o, sym_len_o, err_o, bit_ready_o);
      end
    end
    @(negedge clock);
    start_i     = 1'b1;
    table_sel_i = 2'd1;
    sym_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (rom_addr_o !== 10'd64 || rom_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_restart: addr=%0d en=%b, expected 64 1", rom_addr_o, rom_en_o);
    end
    @(negedge clock);
    start_i     = 1'b0;
    sym_ready_i = 1'b0;
    bit_valid_i = 1'b0;
    #1;
    n_cmp++;
    if (sym_valid_o !== 1'b0 || bit_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_walk: valid=%b ready=%b, expected 0 1", sym_valid_o, bit_ready_o);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      run_decode(int'($urandom_range(0, 2)), $urandom, 0, i > 0, "b2b");
    end
    accept_result("b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_decode(int'($urandom_range(0, 3)), $urandom, 1, 1'b0, "random");
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        @(negedge clock);
        sym_ready_i = 1'b0;
      end
      accept_result("random");
    end
  endtask

  task automatic test_abort();
    @(negedge clock);
    start_i     = 1'b1;
    table_sel_i = 2'd0;
    @(negedge clock);
    start_i     = 1'b0;
    bit_valid_i = 1'b1;
    bit_i       = 1'b0;
    run_decode(2, $urandom, 0, 1'b0, "abort");
    n_cmp++;
    if (last_start_addr != 128) begin
      n_fail++;
      $display("FAIL abort_addr: got %0d, expected 128", last_start_addr);
    end
    accept_result("abort");
  endtask

  task automatic test_reset_mid_walk();
    @(negedge clock);
    start_i     = 1'b1;
    table_sel_i = 2'd0;
    @(negedge clock);
    start_i     = 1'b0;
    bit_valid_i = 1'b1;
    bit_i       = 1'b0;
    @(negedge clock);
    resetn      = 1'b0;
    start_i     = 1'b1;
    #1;
    n_cmp++;
    if (rom_en_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_walk_en: got %b, expected 0", rom_en_o);
    end
    @(negedge clock);
    resetn  = 1'b1;
    start_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      bit_valid_i = 1'b1;
      bit_i       = 1'($urandom_range(0, 1));
      #1;
      n_cmp++;
      if (sym_valid_o !== 1'b0 || bit_ready_o !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_walk_idle: valid=%b ready=%b, expected 0 0", sym_valid_o, bit_ready_o);
      end
    end
  endtask

  initial begin
    int r;
    resetn      = 1'b0;
    start_i     = 1'b0;
    table_sel_i = '0;
    bit_i       = 1'b0;
    bit_valid_i = 1'b0;
    sym_ready_i = 1'b0;
    rom_data_i  = '0;
    for (int a = 0; a < (1 << ROM_ADDR_W); a++) mem[a] = '0;
    mem[0] = {mk(1'b1, 5), mk(1'b0, 1)};
    mem[1] = {mk(1'b0, 8'hFF), mk(1'b1, 3)};
    for (int t = 1; t <= 2; t++) begin
      for (int w = 0; w < 64; w++) begin
        for (int h = 0; h < 2; h++) begin
          r = int'($urandom_range(0, 99));
          if (r < 35)      mem[base_of[t] + w][h*NODE_W +: NODE_W] = mk(1'b1, int'($urandom_range(0, 255)));
          else if (r < 40) mem[base_of[t] + w][h*NODE_W +: NODE_W] = mk(1'b0, 255);
          else             mem[base_of[t] + w][h*NODE_W +: NODE_W] = mk(1'b0, int'($urandom_range(0, 63)));
        end
      end
    end
    mem[192] = {mk(1'b0, 0), mk(1'b0, 0)};

    test_reset();
    test_short_code();
    test_stall();
    test_invalid();
    test_overlength();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid_walk();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
